mem_stage: RTL and testbench

Memory-access stage of the five-stage MIPS pipeline. It consumes the EX/MEM pipeline register outputs produced by the execute stage. It owns the word-addressed data memory and resolves the branch decision (PCSrc) for the fetch stage. It registers load data, ALU result, destination register and write-back controls into the MEM/WB pipeline register that feeds the write-back stage.

---
 rtl/mem_stage.sv | 84 ++++++++
 tb/tb_mem_stage.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the five-stage MIPS pipeline.
// Owns the word-addressed data memory, resolves the branch decision for
// fetch, and registers load data plus write-back controls into MEM/WB.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   Branch_Target_in      branch target from EX/MEM
//   Result_in             ALU result; byte address for loads/stores
//   MemWriteData_in       store data
//   RegDstAddress_in      destination register
//   zero_in               ALU zero flag
//   Branch_in, MemRead_in, MemWrite_in, RegWrite_in, MemtoReg_in  controls
//   PCSrc                 branch taken (combinational)
//   Branch_Target_out     branch target pass-through (combinational)
//   ReadData              registered load data
//   ALUResult             registered ALU result
//   RegDstAddress_out     registered destination register
//   RegWrite_out, MemtoReg_out  registered write-back controls
module mem_stage #(
   parameter int unsigned DEPTH  = 64,
   parameter int unsigned ADDR_W = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Branch_Target_in,
   input  logic [31:0] Result_in,
   input  logic [31:0] MemWriteData_in,
   input  logic [4:0]  RegDstAddress_in,
   input  logic        zero_in,
   input  logic        Branch_in,
   input  logic        MemRead_in,
   input  logic        MemWrite_in,
   input  logic        RegWrite_in,
   input  logic        MemtoReg_in,
   output logic        PCSrc,
   output logic [31:0] Branch_Target_out,
   output logic [31:0] ReadData,
   output logic [31:0] ALUResult,
   output logic [4:0]  RegDstAddress_out,
   output logic        RegWrite_out,
   output logic        MemtoReg_out
);

   localparam int unsigned WORD_W = 32;

   // Zero at power-up; reset deliberately leaves the contents alone.
   logic [WORD_W-1:0] mem [DEPTH] = '{default: '0};

   logic [ADDR_W-1:0] idx;
   logic [WORD_W-1:0] rd_word;

   // Byte offset and high address bits are dropped: aligned, aliased access.
   assign idx     = Result_in[ADDR_W+1:2];
   assign rd_word = mem[idx];

   // Branch resolution goes straight back to fetch, independent of reset.
   assign PCSrc             = Branch_in & zero_in;
   assign Branch_Target_out = Branch_Target_in;

   // Store port; the non-blocking write gives read-first behaviour.
   always_ff @(posedge clk) begin
      if (!reset && MemWrite_in) begin
         mem[idx] <= MemWriteData_in;
      end
   end

   // MEM/WB pipeline register.
   always_ff @(posedge clk) begin
      if (reset) begin
         ReadData          <= '0;
         ALUResult         <= '0;
         RegDstAddress_out <= '0;
         RegWrite_out      <= 1'b0;
         MemtoReg_out      <= 1'b0;
      end else begin
         ReadData          <= MemRead_in ? rd_word : WORD_W'(0);
         ALUResult         <= Result_in;
         RegDstAddress_out <= RegDstAddress_in;
         RegWrite_out      <= RegWrite_in;
         MemtoReg_out      <= MemtoReg_in;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage against a word-array reference model.
module tb_mem_stage;

   localparam int DEPTH = 64;

   logic        clk;
   logic        reset;
   logic [31:0] Branch_Target_in;
   logic [31:0] Result_in;
   logic [31:0] MemWriteData_in;
   logic [4:0]  RegDstAddress_in;
   logic        zero_in;
   logic        Branch_in;
   logic        MemRead_in;
   logic        MemWrite_in;
   logic        RegWrite_in;
   logic        MemtoReg_in;
   logic        PCSrc;
   logic [31:0] Branch_Target_out;
   logic [31:0] ReadData;
   logic [31:0] ALUResult;
   logic [4:0]  RegDstAddress_out;
   logic        RegWrite_out;
   logic        MemtoReg_out;

   int checks = 0;
   int errors = 0;

   logic [31:0] model_mem [DEPTH];
   logic [31:0] exp_rd;
   logic [31:0] exp_alu;
   logic [4:0]  exp_dst;
   logic        exp_rw;
   logic        exp_m2r;

   mem_stage #(.DEPTH(64), .ADDR_W(6)) dut (
      .clk               (clk),
      .reset             (reset),
      .Branch_Target_in  (Branch_Target_in),
      .Result_in         (Result_in),
      .MemWriteData_in   (MemWriteData_in),
      .RegDstAddress_in  (RegDstAddress_in),
      .zero_in           (zero_in),
      .Branch_in         (Branch_in),
      .MemRead_in        (MemRead_in),
      .MemWrite_in       (MemWrite_in),
      .RegWrite_in       (RegWrite_in),
      .MemtoReg_in       (MemtoReg_in),
      .PCSrc             (PCSrc),
      .Branch_Target_out (Branch_Target_out),
      .ReadData          (ReadData),
      .ALUResult         (ALUResult),
      .RegDstAddress_out (RegDstAddress_out),
      .RegWrite_out      (RegWrite_out),
      .MemtoReg_out      (MemtoReg_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Byte address -> word slot: divide by word size, wrap at memory size.
   function automatic int slot(input logic [31:0] addr);
      return int'((addr / 4) % DEPTH);
   endfunction

   task automatic idle_inputs();
      Branch_Target_in = '0; Result_in = '0; MemWriteData_in = '0;
      RegDstAddress_in = '0; zero_in = 0; Branch_in = 0;
      MemRead_in = 0; MemWrite_in = 0; RegWrite_in = 0; MemtoReg_in = 0;
   endtask

   // Predict MEM/WB for the current inputs, update the model, cross one edge.
   task automatic step();
      if (reset) begin
         exp_rd = '0; exp_alu = '0; exp_dst = '0; exp_rw = 0; exp_m2r = 0;
      end else begin
         exp_rd  = MemRead_in ? model_mem[slot(Result_in)] : 32'h0;
         exp_alu = Result_in;
         exp_dst = RegDstAddress_in;
         exp_rw  = RegWrite_in;
         exp_m2r = MemtoReg_in;
         if (MemWrite_in) model_mem[slot(Result_in)] = MemWriteData_in;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [31:0] addr, input logic [4:0] dst);
      idle_inputs();
      Result_in = addr; MemRead_in = 1; MemtoReg_in = 1; RegWrite_in = 1;
      RegDstAddress_in = dst;
      step();
   endtask

   task automatic store(input logic [31:0] addr, input logic [31:0] data);
      idle_inputs();
      Result_in = addr; MemWrite_in = 1; MemWriteData_in = data;
      step();
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1;
      MemWrite_in = 1; Result_in = 32'h10; MemWriteData_in = 32'hDEADBEEF;
      MemRead_in = 1; RegWrite_in = 1; MemtoReg_in = 1; RegDstAddress_in = 5'd7;
      step();
      step();
      checks++;
      if (ReadData !== 32'h0) begin
         errors++; $display("FAIL reset_readdata got %h want 0", ReadData);
      end
      checks++;
      if (ALUResult !== 32'h0) begin
         errors++; $display("FAIL reset_aluresult got %h want 0", ALUResult);
      end
      checks++;
      if ({RegDstAddress_out, RegWrite_out, MemtoReg_out} !== 7'h0) begin
         errors++;
         $display("FAIL reset_ctrl got dst=%0d rw=%b m2r=%b want 0/0/0",
                  RegDstAddress_out, RegWrite_out, MemtoReg_out);
      end
      reset = 0;
      load(32'h10, 5'd3);
      checks++;
      if (ReadData !== 32'h0) begin
         errors++; $display("FAIL reset_store_lost got %h want 00000000", ReadData);
      end
   endtask

   task automatic test_store_load();
      store(32'h08, 32'h12345678);
      load(32'h08, 5'd9);
      checks++;
      if (ReadData !== 32'h12345678) begin
         errors++; $display("FAIL store_load_data got %h want 12345678", ReadData);
      end
      checks++;
      if (MemtoReg_out !== 1'b1 || RegDstAddress_out !== 5'd9) begin
         errors++;
         $display("FAIL store_load_ctrl got m2r=%b dst=%0d want 1/9",
                  MemtoReg_out, RegDstAddress_out);
      end
   endtask

   task automatic test_read_first();
      store(32'h0C, 32'hAAAA0000);
      idle_inputs();
      Result_in = 32'h0C; MemRead_in = 1; MemWrite_in = 1;
      MemWriteData_in = 32'h5555FFFF;
      step();
      checks++;
      if (ReadData !== 32'hAAAA0000) begin
         errors++; $display("FAIL read_first_old got %h want aaaa0000", ReadData);
      end
      load(32'h0C, 5'd1);
      checks++;
      if (ReadData !== 32'h5555FFFF) begin
         errors++; $display("FAIL read_first_new got %h want 5555ffff", ReadData);
      end
   endtask

   task automatic test_alias();
      store(32'h104, 32'hCAFEF00D);
      load(32'h004, 5'd2);
      checks++;
      if (ReadData !== 32'hCAFEF00D) begin
         errors++; $display("FAIL alias_004 got %h want cafef00d", ReadData);
      end
      load(32'h107, 5'd2);
      checks++;
      if (ReadData !== 32'hCAFEF00D) begin
         errors++; $display("FAIL alias_107 got %h want cafef00d", ReadData);
      end
   endtask

   task automatic test_branch();
      idle_inputs();
      Branch_in = 1; zero_in = 1; Branch_Target_in = 32'h40;
      #1;
      checks++;
      if (PCSrc !== 1'b1 || Branch_Target_out !== 32'h40) begin
         errors++;
         $display("FAIL branch_taken got pcsrc=%b tgt=%h want 1/00000040",
                  PCSrc, Branch_Target_out);
      end
      zero_in = 0;
      #1;
      checks++;
      if (PCSrc !== 1'b0) begin
         errors++; $display("FAIL branch_not_taken got pcsrc=%b want 0", PCSrc);
      end
      // Branch decision is not gated by reset.
      reset = 1; zero_in = 1;
      #1;
      checks++;
      if (PCSrc !== 1'b1) begin
         errors++; $display("FAIL branch_in_reset got pcsrc=%b want 1", PCSrc);
      end
      reset = 0;
      idle_inputs();
      step();
   endtask

   task automatic test_passthrough();
      idle_inputs();
      Result_in = 32'h77; RegWrite_in = 1; RegDstAddress_in = 5'd21;
      step();
      checks++;
      if (ReadData !== 32'h0 || ALUResult !== 32'h77 || RegWrite_out !== 1'b1
          || RegDstAddress_out !== 5'd21 || MemtoReg_out !== 1'b0) begin
         errors++;
         $display("FAIL passthrough got rd=%h alu=%h rw=%b dst=%0d m2r=%b want 0/77/1/21/0",
                  ReadData, ALUResult, RegWrite_out, RegDstAddress_out, MemtoReg_out);
      end
   endtask

   task automatic test_reset_midstream();
      store(32'h20, 32'h0BADF00D);
      idle_inputs();
      reset = 1;
      MemWrite_in = 1; Result_in = 32'h20; MemWriteData_in = 32'hFFFFFFFF;
      RegWrite_in = 1;
      step();
      checks++;
      if (ALUResult !== 32'h0 || RegWrite_out !== 1'b0) begin
         errors++;
         $display("FAIL midreset_clear got alu=%h rw=%b want 0/0", ALUResult, RegWrite_out);
      end
      reset = 0;
      load(32'h20, 5'd4);
      checks++;
      if (ReadData !== 32'h0BADF00D) begin
         errors++; $display("FAIL midreset_persist got %h want 0badf00d", ReadData);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         logic exp_pc;
         Result_in = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 2)
                     | 32'($urandom_range(0, 3));
         MemWriteData_in  = $urandom;
         Branch_Target_in = $urandom;
         RegDstAddress_in = 5'($urandom);
         zero_in     = 1'($urandom);
         Branch_in   = 1'($urandom);
         MemRead_in  = 1'($urandom);
         MemWrite_in = 1'($urandom);
         RegWrite_in = 1'($urandom);
         MemtoReg_in = 1'($urandom);
         reset       = ($urandom_range(0, 19) == 0);
         #1;
         exp_pc = Branch_in && zero_in;
         checks++;
         if (PCSrc !== exp_pc || Branch_Target_out !== Branch_Target_in) begin
            errors++;
            $display("FAIL rand_branch[%0d] got pcsrc=%b tgt=%h want %b/%h",
                     i, PCSrc, Branch_Target_out, exp_pc, Branch_Target_in);
         end
         step();
         checks++;
         if (ReadData !== exp_rd || ALUResult !== exp_alu || RegDstAddress_out !== exp_dst
             || RegWrite_out !== exp_rw || MemtoReg_out !== exp_m2r) begin
            errors++;
            $display("FAIL rand_memwb[%0d] got rd=%h alu=%h dst=%0d rw=%b m2r=%b want %h/%h/%0d/%b/%b",
                     i, ReadData, ALUResult, RegDstAddress_out, RegWrite_out, MemtoReg_out,
                     exp_rd, exp_alu, exp_dst, exp_rw, exp_m2r);
         end
      end
      reset = 0;
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      reset = 1;
      idle_inputs();
      test_reset();
      test_store_load();
      test_read_first();
      test_alias();
      test_branch();
      test_passthrough();
      test_reset_midstream();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
